// File: rtl/audio_transport_ctrl_pkg.sv
// Shared types and slot-address helpers for the audio transport controller.
// Slot regions are equal power-of-two slices of the SRAM word space.
package audio_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        IDLE       = 3'd1,
        RECD       = 3'd2,
        RECD_PAUSE = 3'd3,
        PLAY       = 3'd4,
        PLAY_PAUSE = 3'd5
    } state_e;

    function automatic logic [31:0] slot_base(input logic [31:0] slot, input int unsigned slot_w);
        return slot << slot_w;
    endfunction

    function automatic logic [31:0] slot_limit(input logic [31:0] slot, input int unsigned slot_w);
        return slot_base(slot, slot_w) + ((32'd1 << slot_w) - 32'd1);
    endfunction

endpackage

// File: rtl/audio_transport_ctrl_if.sv
// Key, codec, recorder/DSP/player command bundle of the transport controller.
// master = the controller, slave = the surrounding datapath and front panel.
interface audio_transport_ctrl_if #(
    parameter int ADDR_W  = 20,
    parameter int N_SLOTS = 4,
    parameter int SPEED_W = 4
);
    localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic              i_key_rec;
    logic              i_key_play;
    logic              i_key_stop;
    logic [SEL_W-1:0]  i_slot_sel;
    logic [SPEED_W-1:0] i_speed;
    logic              i_i2c_fin;
    logic [ADDR_W-1:0] i_rec_addr;
    logic [ADDR_W-1:0] i_play_addr;
    logic              o_i2c_start;
    logic              o_rec_start;
    logic              o_rec_pause;
    logic              o_rec_stop;
    logic              o_dsp_start;
    logic              o_dsp_pause;
    logic              o_dsp_stop;
    logic              o_play_en;
    logic [ADDR_W-1:0] o_base_addr;
    logic [ADDR_W-1:0] o_end_addr;
    logic [SPEED_W-1:0] o_speed;
    logic [2:0]        o_state;
    logic [SEL_W-1:0]  o_slot;

    modport master (
        input  i_key_rec, i_key_play, i_key_stop, i_slot_sel, i_speed, i_i2c_fin,
               i_rec_addr, i_play_addr,
        output o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start,
               o_dsp_pause, o_dsp_stop, o_play_en, o_base_addr, o_end_addr,
               o_speed, o_state, o_slot
    );

    modport slave (
        output i_key_rec, i_key_play, i_key_stop, i_slot_sel, i_speed, i_i2c_fin,
               i_rec_addr, i_play_addr,
        input  o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start,
               o_dsp_pause, o_dsp_stop, o_play_en, o_base_addr, o_end_addr,
               o_speed, o_state, o_slot
    );
endinterface

// File: rtl/audio_transport_ctrl_slot_table.sv
// Per-slot recorded-length register file: one write port, one combinational
// read port, and an empty flag for every slot (length zero).
module audio_slot_table #(
    parameter int ADDR_W  = 20,
    parameter int N_SLOTS = 4,
    parameter int SEL_W   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [SEL_W-1:0]   i_waddr,
    input  logic [ADDR_W:0]    i_wdata,
    input  logic [SEL_W-1:0]   i_raddr,
    output logic [ADDR_W:0]    o_rdata,
    output logic [N_SLOTS-1:0] o_empty
);
    logic [ADDR_W:0] len_q [N_SLOTS];
    logic [ADDR_W:0] len_d [N_SLOTS];

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            len_d[i] = len_q[i];
            if (i_we && (i_waddr == SEL_W'(i))) len_d[i] = i_wdata;
            if (i_raddr == SEL_W'(i)) o_rdata = len_q[i];
            o_empty[i] = (len_q[i] == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_SLOTS; i++) begin
            if (i_rst) len_q[i] <= '0;
            else       len_q[i] <= len_d[i];
        end
    end
endmodule

// File: rtl/audio_transport_ctrl.sv
// Record/playback transport FSM: codec init, then per-slot record, play,
// pause and stop with automatic stop on slot-full and end-of-playback.
module audio_transport_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int N_SLOTS     = 4,
    parameter int INIT_CYCLES = 2048,
    parameter int SPEED_W     = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    audio_transport_ctrl_if.master bus
);
    localparam int LOG2N  = $clog2(N_SLOTS);
    localparam int SEL_W  = (N_SLOTS > 1) ? LOG2N : 1;
    localparam int SLOT_W = ADDR_W - LOG2N;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(INIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   slot_q, slot_d, sel;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [ADDR_W-1:0]  base_q, base_d, end_q, end_d;
    logic [ADDR_W-1:0]  sel_base, sel_limit, play_end;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   sel_len, rec_len, wr_len;
    logic [N_SLOTS-1:0] empty;
    logic [SEL_W-1:0]   wr_slot;
    logic               wr_en, sel_empty, unused_len_msb;
    logic i2c_start_q, i2c_start_d, play_en_q, play_en_d;
    logic rec_start_q, rec_start_d, rec_pause_q, rec_pause_d, rec_stop_q, rec_stop_d;
    logic dsp_start_q, dsp_start_d, dsp_pause_q, dsp_pause_d, dsp_stop_q, dsp_stop_d;

    assign sel       = (N_SLOTS == 1) ? '0 : bus.i_slot_sel;
    assign sel_base  = ADDR_W'(slot_base(32'(sel), SLOT_W));
    assign sel_limit = ADDR_W'(slot_limit(32'(sel), SLOT_W));
    // Wraps modulo 2^ADDR_W, so a completely full single-slot SRAM still ends at all-ones.
    assign play_end  = sel_base + sel_len[ADDR_W-1:0] - ADDR_W'(1);
    assign rec_len   = {1'b0, bus.i_rec_addr - base_q} + LEN_W'(1);
    assign unused_len_msb = sel_len[ADDR_W];

    always_comb begin
        sel_empty = 1'b0;
        for (int i = 0; i < N_SLOTS; i++)
            if (sel == SEL_W'(i)) sel_empty = empty[i];
    end

    audio_slot_table #(.ADDR_W(ADDR_W), .N_SLOTS(N_SLOTS), .SEL_W(SEL_W)) u_slot_table (
        .i_clk(i_clk), .i_rst(i_rst), .i_we(wr_en), .i_waddr(wr_slot), .i_wdata(wr_len),
        .i_raddr(sel), .o_rdata(sel_len), .o_empty(empty)
    );

    always_comb begin
        state_d = state_q;  slot_d = slot_q;  speed_d = speed_q;
        base_d = base_q;    end_d = end_q;    cnt_d = cnt_q;
        i2c_start_d = 1'b0; play_en_d = play_en_q;
        rec_start_d = 1'b0; rec_pause_d = 1'b0; rec_stop_d = 1'b0;
        dsp_start_d = 1'b0; dsp_pause_d = 1'b0; dsp_stop_d = 1'b0;
        wr_en = 1'b0;       wr_slot = slot_q; wr_len = rec_len;
        case (state_q)
            INIT: begin
                if (bus.i_i2c_fin) begin
                    state_d = IDLE;
                end else if (cnt_q < INIT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    i2c_start_d = 1'b1;
                end
            end
            IDLE: begin
                if (!bus.i_key_stop) begin
                    if (bus.i_key_rec) begin
                        state_d = RECD;  slot_d = sel;  rec_start_d = 1'b1;
                        base_d = sel_base;  end_d = sel_limit;
                        wr_en = 1'b1;  wr_slot = sel;  wr_len = '0;
                    end else if (bus.i_key_play && !sel_empty) begin
                        state_d = PLAY;  slot_d = sel;  dsp_start_d = 1'b1;
                        play_en_d = 1'b1;  speed_d = bus.i_speed;
                        base_d = sel_base;  end_d = play_end;
                    end
                end
            end
            RECD, RECD_PAUSE: begin
                // Address-full only auto-stops while actually recording.
                if (bus.i_key_stop || (state_q == RECD && bus.i_rec_addr == end_q)) begin
                    state_d = IDLE;  rec_stop_d = 1'b1;  wr_en = 1'b1;
                end else if (bus.i_key_rec) begin
                    state_d     = (state_q == RECD) ? RECD_PAUSE : RECD;
                    rec_pause_d = (state_q == RECD);
                    rec_start_d = (state_q == RECD_PAUSE);
                end
            end
            PLAY, PLAY_PAUSE: begin
                if (bus.i_key_stop || (state_q == PLAY && bus.i_play_addr >= end_q)) begin
                    state_d = IDLE;  dsp_stop_d = 1'b1;  play_en_d = 1'b0;
                end else if (bus.i_key_play) begin
                    state_d     = (state_q == PLAY) ? PLAY_PAUSE : PLAY;
                    dsp_pause_d = (state_q == PLAY);
                    dsp_start_d = (state_q == PLAY_PAUSE);
                    play_en_d   = (state_q == PLAY_PAUSE);
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= INIT;  slot_q <= '0;  speed_q <= '0;  base_q <= '0;  end_q <= '0;
            cnt_q <= '0;  i2c_start_q <= 1'b0;  play_en_q <= 1'b0;
            rec_start_q <= 1'b0;  rec_pause_q <= 1'b0;  rec_stop_q <= 1'b0;
            dsp_start_q <= 1'b0;  dsp_pause_q <= 1'b0;  dsp_stop_q <= 1'b0;
        end else begin
            state_q <= state_d;  slot_q <= slot_d;  speed_q <= speed_d;
            base_q <= base_d;    end_q <= end_d;    cnt_q <= cnt_d;
            i2c_start_q <= i2c_start_d;  play_en_q <= play_en_d;
            rec_start_q <= rec_start_d;  rec_pause_q <= rec_pause_d;  rec_stop_q <= rec_stop_d;
            dsp_start_q <= dsp_start_d;  dsp_pause_q <= dsp_pause_d;  dsp_stop_q <= dsp_stop_d;
        end
    end

    assign bus.o_state     = state_q;
    assign bus.o_slot      = slot_q;
    assign bus.o_speed     = speed_q;
    assign bus.o_base_addr = base_q;
    assign bus.o_end_addr  = end_q;
    assign bus.o_i2c_start = i2c_start_q;
    assign bus.o_play_en   = play_en_q;
    assign bus.o_rec_start = rec_start_q;
    assign bus.o_rec_pause = rec_pause_q;
    assign bus.o_rec_stop  = rec_stop_q;
    assign bus.o_dsp_start = dsp_start_q;
    assign bus.o_dsp_pause = dsp_pause_q;
    assign bus.o_dsp_stop  = dsp_stop_q;
endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Directed plus randomized bench for audio_transport_ctrl against a transaction-level
// model of the transport rules (ADDR_W=20, N_SLOTS=4, INIT_CYCLES=2048).
module tb_audio_transport_ctrl;
    localparam int      INIT_CYCLES = 2048;
    localparam longint  SLOT_SIZE   = 64'h40000;
    localparam longint  AMASK       = 64'hFFFFF;
    localparam int M_INIT = 0, M_IDLE = 1, M_RECD = 2, M_RPAUSE = 3, M_PLAY = 4, M_PPAUSE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_transport_ctrl_if #(.ADDR_W(20), .N_SLOTS(4), .SPEED_W(4)) bus ();

    audio_transport_ctrl #(.ADDR_W(20), .N_SLOTS(4), .INIT_CYCLES(INIT_CYCLES), .SPEED_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    int     m_state, m_slot, m_speed, m_cyc;
    longint m_base, m_end;
    longint m_len [4];
    bit     m_i2c, m_play_en;
    logic [5:0] m_pulse;  // {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: what the controller must show after the coming clock edge.
    task automatic model_edge();
        longint sel, stored;
        m_pulse = '0;
        sel = longint'(bus.i_slot_sel);
        if (rst) begin
            m_state = M_INIT; m_slot = 0; m_speed = 0; m_base = 0; m_end = 0;
            m_i2c = 0; m_play_en = 0; m_cyc = 0;
            for (int i = 0; i < 4; i++) m_len[i] = 0;
            return;
        end
        stored = ((longint'(bus.i_rec_addr) - m_base) & AMASK) + 1;
        m_i2c = 0;
        case (m_state)
            M_INIT: begin
                if (bus.i_i2c_fin) m_state = M_IDLE;
                else begin m_cyc++; m_i2c = (m_cyc <= INIT_CYCLES - 1); end
            end
            M_IDLE: begin
                if (bus.i_key_stop) begin end
                else if (bus.i_key_rec) begin
                    m_state = M_RECD; m_slot = int'(sel); m_pulse[5] = 1;
                    m_len[sel] = 0; m_base = sel * SLOT_SIZE; m_end = m_base + SLOT_SIZE - 1;
                end else if (bus.i_key_play && m_len[sel] != 0) begin
                    m_state = M_PLAY; m_slot = int'(sel); m_pulse[2] = 1; m_play_en = 1;
                    m_speed = int'(bus.i_speed); m_base = sel * SLOT_SIZE;
                    m_end = (m_base + m_len[sel] - 1) & AMASK;
                end
            end
            M_RECD, M_RPAUSE: begin
                if (bus.i_key_stop || (m_state == M_RECD && longint'(bus.i_rec_addr) == m_end)) begin
                    m_state = M_IDLE; m_pulse[3] = 1; m_len[m_slot] = stored;
                end else if (bus.i_key_rec) begin
                    if (m_state == M_RECD) begin m_state = M_RPAUSE; m_pulse[4] = 1; end
                    else begin m_state = M_RECD; m_pulse[5] = 1; end
                end
            end
            M_PLAY, M_PPAUSE: begin
                if (bus.i_key_stop || (m_state == M_PLAY && longint'(bus.i_play_addr) >= m_end)) begin
                    m_state = M_IDLE; m_pulse[0] = 1; m_play_en = 0;
                end else if (bus.i_key_play) begin
                    if (m_state == M_PLAY) begin m_state = M_PPAUSE; m_pulse[1] = 1; m_play_en = 0; end
                    else begin m_state = M_PLAY; m_pulse[2] = 1; m_play_en = 1; end
                end
            end
            default: m_state = M_INIT;
        endcase
    endtask

    task automatic check_all();
        chk("state", 64'(bus.o_state), 64'(m_state));
        chk("pulses", 64'({bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                          bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop}), 64'(m_pulse));
        chk("play_en", 64'(bus.o_play_en), 64'(m_play_en));
        chk("i2c_start", 64'(bus.o_i2c_start), 64'(m_i2c));
        chk("slot", 64'(bus.o_slot), 64'(m_slot));
        chk("speed", 64'(bus.o_speed), 64'(m_speed));
        chk("base_addr", 64'(bus.o_base_addr), 64'(m_base));
        chk("end_addr", 64'(bus.o_end_addr), 64'(m_end));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        bus.i_key_rec = 0; bus.i_key_play = 0; bus.i_key_stop = 0;
    endtask

    task automatic press(input bit rec, input bit play, input bit stop);
        bus.i_key_rec = rec; bus.i_key_play = play; bus.i_key_stop = stop;
        step();
    endtask

    initial begin
        int hi;
        bus.i_key_rec = 0; bus.i_key_play = 0; bus.i_key_stop = 0;
        bus.i_slot_sel = 0; bus.i_speed = 0; bus.i_i2c_fin = 0;
        bus.i_rec_addr = 0; bus.i_play_addr = 0;

        // Reset, then the codec start window with no init-done.
        rst = 1; repeat (3) step();
        rst = 0; hi = 0;
        for (int i = 0; i < INIT_CYCLES + 4; i++) begin
            press(1, 1, 0);
            if (bus.o_i2c_start) hi++;
        end
        chk("i2c_hi_cycles", 64'(hi), 64'd2047);
        bus.i_i2c_fin = 1; step();
        chk("idle_after_fin", 64'(bus.o_state), 64'd1);

        // Slot 2 record stopped at 0x80010 -> length 17.
        bus.i_slot_sel = 2; press(1, 0, 0);
        bus.i_rec_addr = 20'h80008; press(0, 1, 0);
        bus.i_rec_addr = 20'h80010; press(0, 0, 1);
        bus.i_speed = 4'd5; bus.i_play_addr = 20'h80000; press(0, 1, 0);
        chk("len17_end_addr", 64'(bus.o_end_addr), 64'h80010);
        chk("len17_speed", 64'(bus.o_speed), 64'd5);

        // Pause, resume, then run to the end: exactly one dsp stop.
        bus.i_play_addr = 20'h80005; press(0, 1, 0); press(1, 0, 0); press(0, 1, 0);
        bus.i_play_addr = 20'h80010; step();
        chk("end_play_stop", 64'(bus.o_dsp_stop), 64'd1);
        step();
        chk("single_dsp_stop", 64'(bus.o_dsp_stop), 64'd0);

        // Record until slot 2 is full -> auto stop, length 0x40000.
        press(1, 0, 0);
        bus.i_rec_addr = 20'h80100; step(); press(1, 0, 0); press(1, 0, 0);
        bus.i_rec_addr = 20'hBFFFF; step();
        chk("full_rec_stop", 64'(bus.o_rec_stop), 64'd1);
        press(0, 1, 0);
        chk("full_end_addr", 64'(bus.o_end_addr), 64'hBFFFF);
        press(0, 0, 1);

        // Empty slot 3 play is ignored.
        bus.i_slot_sel = 3; press(0, 1, 0);
        chk("empty_play_dsp", 64'(bus.o_dsp_start), 64'd0);

        // Stop + rec together in RECD, then stop from record-pause.
        bus.i_slot_sel = 1; press(1, 0, 0);
        bus.i_rec_addr = 20'h40003; press(1, 0, 1);
        press(1, 0, 0); press(1, 0, 0);
        bus.i_rec_addr = 20'h40009; press(0, 0, 1);

        // Randomized key traffic.
        for (int i = 0; i < 400; i++) begin
            bus.i_slot_sel = 2'($urandom_range(0, 3));
            bus.i_speed    = 4'($urandom);
            bus.i_rec_addr = ($urandom_range(0, 15) == 0) ? 20'(m_end)
                                                          : 20'(m_base + longint'($urandom_range(0, 63)));
            bus.i_play_addr = 20'(m_base + longint'($urandom_range(0, 70)));
            press(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 4) == 0),
                  bit'($urandom_range(0, 9) == 0));
        end

        // Reset in the middle of playback.
        press(0, 0, 1);
        bus.i_slot_sel = 0; press(1, 0, 0);
        bus.i_rec_addr = 20'h00020; press(0, 0, 1);
        bus.i_play_addr = 20'h00000; press(0, 1, 0);
        chk("pre_reset_play", 64'(bus.o_state), 64'd4);
        rst = 1; step();
        chk("reset_no_stop", 64'(bus.o_dsp_stop), 64'd0);
        rst = 0; step();
        press(0, 1, 0);
        chk("cleared_len_play", 64'(bus.o_play_en), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
